su_add_sched: RTL and testbench

- Scheduler that sequences the spatial-unrolling adder (su_adder) across PE-array psum tiles.
- Latches the layer config (irrel/rel group sizes, RF entries per tile, tile count) and waits for the PE array's pe_psum_finish.
- Steps su_adder through every psum RF entry, then handshakes the tile back to the PE array.
- Arbitrates the single psum GBF port between su_adder and the output-drain requester, and raises conv_finish after the last tile.

---
 rtl/su_add_sched_pkg.sv | 30 +++
 rtl/su_add_sched_if.sv | 29 ++
 rtl/su_add_sched_gbf_arb.sv | 32 +++
 rtl/su_add_sched.sv | 198 +++++++++++++++++++
 tb/tb_su_add_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/su_add_sched_pkg.sv
// Shared types and helpers for the su_adder scheduler (package su_sched_pkg).
// No configuration macros are used in this file.
package su_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PE,
        START,
        ADD,
        TILE_END
    } sched_state_e;

    localparam int unsigned MAX_PE_GROUP = 16;

    // A config is legal when the PE group fits the array and every count is non-zero.
    function automatic logic cfg_legal(
        input logic [4:0]  irrel,
        input logic [4:0]  rel,
        input int unsigned rf_num,
        input int unsigned rf_max,
        input logic        tile_nz
    );
        int unsigned prod;
        prod = {27'd0, irrel} * {27'd0, rel};
        return (irrel != 5'd0) && ({27'd0, irrel} <= MAX_PE_GROUP) &&
               (rel != 5'd0) && (prod <= MAX_PE_GROUP) &&
               (rf_num != 0) && (rf_num <= rf_max) && tile_nz;
    endfunction

endpackage

// File: rtl/su_add_sched_if.sv
// Psum GBF port bundle shared by su_adder, the drain requester and the scheduler mux.
// No configuration macros are used in this file.
interface su_add_sched_if #(
    parameter int unsigned GBF_ADDR_BITWIDTH = 5
);
    logic                         su_gbf_r_en;
    logic                         su_gbf_w_en;
    logic [GBF_ADDR_BITWIDTH-1:0] su_gbf_r_addr;
    logic [GBF_ADDR_BITWIDTH-1:0] su_gbf_w_addr;
    logic                         drain_req;
    logic [GBF_ADDR_BITWIDTH-1:0] drain_addr;
    logic                         drain_gnt;
    logic                         gbf_r_en;
    logic                         gbf_w_en;
    logic [GBF_ADDR_BITWIDTH-1:0] gbf_r_addr;
    logic [GBF_ADDR_BITWIDTH-1:0] gbf_w_addr;

    modport master (
        input  su_gbf_r_en, su_gbf_w_en, su_gbf_r_addr, su_gbf_w_addr,
        input  drain_req, drain_addr,
        output drain_gnt, gbf_r_en, gbf_w_en, gbf_r_addr, gbf_w_addr
    );

    modport slave (
        output su_gbf_r_en, su_gbf_w_en, su_gbf_r_addr, su_gbf_w_addr,
        output drain_req, drain_addr,
        input  drain_gnt, gbf_r_en, gbf_w_en, gbf_r_addr, gbf_w_addr
    );
endinterface

// File: rtl/su_add_sched_gbf_arb.sv
// su_gbf_arb: psum GBF port mux. su_adder owns the port while su_own_i is high;
// drain reads only. No configuration macros are used in this file.
module su_gbf_arb #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              su_own_i,
    input  logic              su_r_en_i,
    input  logic              su_w_en_i,
    input  logic [ADDR_W-1:0] su_r_addr_i,
    input  logic [ADDR_W-1:0] su_w_addr_i,
    input  logic              drain_req_i,
    input  logic [ADDR_W-1:0] drain_addr_i,
    output logic              drain_gnt_o,
    output logic              r_en_o,
    output logic              w_en_o,
    output logic [ADDR_W-1:0] r_addr_o,
    output logic [ADDR_W-1:0] w_addr_o
);

    always_comb begin
        drain_gnt_o = drain_req_i && (!su_own_i || (!su_r_en_i && !su_w_en_i));
        r_en_o      = su_r_en_i;
        r_addr_o    = su_r_addr_i;
        w_en_o      = su_w_en_i;
        w_addr_o    = su_w_addr_i;
        if (drain_gnt_o) begin
            r_en_o   = 1'b1;
            r_addr_o = drain_addr_i;
        end
    end

endmodule

// File: rtl/su_add_sched.sv
// su_add_sched: steps su_adder through each psum RF entry of every PE tile and muxes the psum GBF port.
// Define SU_SCHED_PERF_CNT_EN to add the perf_add_cycles / perf_drain_stall counters.
module su_add_sched
    import su_sched_pkg::*;
#(
    parameter int unsigned PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int unsigned GBF_ADDR_BITWIDTH     = 5,
    parameter int unsigned TILE_CNT_BITWIDTH     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_valid,
    input  logic [4:0]                       cfg_irrel_num,
    input  logic [4:0]                       cfg_rel_num,
    input  logic [PSUM_RF_ADDR_BITWIDTH:0]   cfg_rf_num,
    input  logic [TILE_CNT_BITWIDTH-1:0]     cfg_tile_num,
    output logic                             cfg_err,
    input  logic                             pe_psum_finish,
    output logic                             pe_psum_ack,
    output logic [4:0]                       su_irrel_num,
    output logic [4:0]                       su_rel_num,
    output logic                             su_start,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr,
    input  logic                             su_add_finish,
    output logic                             conv_finish,
    output logic                             busy,
`ifdef SU_SCHED_PERF_CNT_EN
    output logic [31:0]                      perf_add_cycles,
    output logic [31:0]                      perf_drain_stall,
`endif
    su_add_sched_if.master                   gbf
);

    localparam int unsigned RFW    = PSUM_RF_ADDR_BITWIDTH;
    localparam int unsigned TCW    = TILE_CNT_BITWIDTH;
    localparam int unsigned RF_MAX = 1 << RFW;

    sched_state_e   state_q, state_d;
    logic [4:0]     irrel_q, irrel_d;
    logic [4:0]     rel_q, rel_d;
    logic [RFW:0]   rf_num_q, rf_num_d;
    logic [TCW-1:0] tile_num_q, tile_num_d;
    logic [RFW-1:0] rf_idx_q, rf_idx_d;
    logic [TCW-1:0] tile_cnt_q, tile_cnt_d;
    logic           cfg_err_q, cfg_err_d;
    logic           conv_fin_q, conv_fin_d;
    logic           finish_q, finish_d;
    logic           ack_hold_q, ack_hold_d;

    logic cfg_ok;
    logic cfg_accept;
    logic rf_last;
    logic su_phase;

    assign cfg_ok     = cfg_legal(cfg_irrel_num, cfg_rel_num, 32'(cfg_rf_num), RF_MAX, |cfg_tile_num);
    assign cfg_accept = (state_q == IDLE) && cfg_valid && cfg_ok;
    assign rf_last    = (({1'b0, rf_idx_q} + (RFW+1)'(1)) == rf_num_q);
    assign su_phase   = (state_q == START) || (state_q == ADD);

    // su_add_finish is registered first, giving the two-cycle finish-to-start turnaround;
    // ack_hold masks pe_psum_finish for the cycle the PE array needs to drop it.
    always_comb begin
        state_d    = state_q;
        irrel_d    = irrel_q;
        rel_d      = rel_q;
        rf_num_d   = rf_num_q;
        tile_num_d = tile_num_q;
        rf_idx_d   = rf_idx_q;
        tile_cnt_d = tile_cnt_q;
        cfg_err_d  = 1'b0;
        conv_fin_d = 1'b0;
        finish_d   = su_add_finish && (state_q == ADD);
        ack_hold_d = (state_q == TILE_END);
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        irrel_d    = cfg_irrel_num;
                        rel_d      = cfg_rel_num;
                        rf_num_d   = cfg_rf_num;
                        tile_num_d = cfg_tile_num;
                        state_d    = WAIT_PE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            WAIT_PE: begin
                if (pe_psum_finish && !ack_hold_q) begin
                    rf_idx_d = '0;
                    state_d  = START;
                end
            end
            START: state_d = ADD;
            ADD: begin
                if (finish_q) begin
                    if (!rf_last) begin
                        rf_idx_d = rf_idx_q + RFW'(1);
                        state_d  = START;
                    end else begin
                        tile_cnt_d = tile_cnt_q + TCW'(1);
                        state_d    = TILE_END;
                    end
                end
            end
            TILE_END: begin
                if (tile_cnt_q == tile_num_q) begin
                    conv_fin_d = 1'b1;
                    tile_cnt_d = '0;
                    rf_idx_d   = '0;
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT_PE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            irrel_q    <= '0;
            rel_q      <= '0;
            rf_num_q   <= '0;
            tile_num_q <= '0;
            rf_idx_q   <= '0;
            tile_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            conv_fin_q <= 1'b0;
            finish_q   <= 1'b0;
            ack_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            irrel_q    <= irrel_d;
            rel_q      <= rel_d;
            rf_num_q   <= rf_num_d;
            tile_num_q <= tile_num_d;
            rf_idx_q   <= rf_idx_d;
            tile_cnt_q <= tile_cnt_d;
            cfg_err_q  <= cfg_err_d;
            conv_fin_q <= conv_fin_d;
            finish_q   <= finish_d;
            ack_hold_q <= ack_hold_d;
        end
    end

    assign cfg_err      = cfg_err_q;
    assign pe_psum_ack  = (state_q == TILE_END);
    assign su_irrel_num = irrel_q;
    assign su_rel_num   = rel_q;
    assign su_start     = (state_q == START);
    assign psum_rf_addr = rf_idx_q;
    assign conv_finish  = conv_fin_q;
    assign busy         = (state_q != IDLE);

    su_gbf_arb #(
        .ADDR_W (GBF_ADDR_BITWIDTH)
    ) u_arb (
        .su_own_i     (su_phase),
        .su_r_en_i    (gbf.su_gbf_r_en),
        .su_w_en_i    (gbf.su_gbf_w_en),
        .su_r_addr_i  (gbf.su_gbf_r_addr),
        .su_w_addr_i  (gbf.su_gbf_w_addr),
        .drain_req_i  (gbf.drain_req),
        .drain_addr_i (gbf.drain_addr),
        .drain_gnt_o  (gbf.drain_gnt),
        .r_en_o       (gbf.gbf_r_en),
        .w_en_o       (gbf.gbf_w_en),
        .r_addr_o     (gbf.gbf_r_addr),
        .w_addr_o     (gbf.gbf_w_addr)
    );

`ifdef SU_SCHED_PERF_CNT_EN
    logic [31:0] perf_add_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_add_q   <= '0;
            perf_stall_q <= '0;
        end else if (cfg_accept) begin
            perf_add_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (su_phase && (perf_add_q != '1)) perf_add_q <= perf_add_q + 32'd1;
            if (gbf.drain_req && !gbf.drain_gnt && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_add_cycles  = perf_add_q;
    assign perf_drain_stall = perf_stall_q;
`else
    logic unused_accept;
    assign unused_accept = cfg_accept;
`endif

endmodule

// File: tb/tb_su_add_sched.sv
// Directed bench for su_add_sched: config table, arbitration table and multi-cycle job sequences.
// Builds with or without SU_SCHED_PERF_CNT_EN.
module tb_su_add_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [4:0]  cfg_irrel_num, cfg_rel_num;
    logic [2:0]  cfg_rf_num;
    logic [15:0] cfg_tile_num;
    logic        cfg_err, pe_psum_finish, pe_psum_ack;
    logic [4:0]  su_irrel_num, su_rel_num;
    logic        su_start, su_add_finish, conv_finish, busy;
    logic [1:0]  psum_rf_addr;
`ifdef SU_SCHED_PERF_CNT_EN
    logic [31:0] perf_add_cycles, perf_drain_stall;
`endif

    su_add_sched_if #(.GBF_ADDR_BITWIDTH(5)) gbf_if();

    su_add_sched #(
        .PSUM_RF_ADDR_BITWIDTH (2),
        .GBF_ADDR_BITWIDTH     (5),
        .TILE_CNT_BITWIDTH     (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_irrel_num  (cfg_irrel_num),
        .cfg_rel_num    (cfg_rel_num),
        .cfg_rf_num     (cfg_rf_num),
        .cfg_tile_num   (cfg_tile_num),
        .cfg_err        (cfg_err),
        .pe_psum_finish (pe_psum_finish),
        .pe_psum_ack    (pe_psum_ack),
        .su_irrel_num   (su_irrel_num),
        .su_rel_num     (su_rel_num),
        .su_start       (su_start),
        .psum_rf_addr   (psum_rf_addr),
        .su_add_finish  (su_add_finish),
        .conv_finish    (conv_finish),
        .busy           (busy),
`ifdef SU_SCHED_PERF_CNT_EN
        .perf_add_cycles  (perf_add_cycles),
        .perf_drain_stall (perf_drain_stall),
`endif
        .gbf            (gbf_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  irrel;
        logic [4:0]  rel;
        logic [2:0]  rf;
        logic [15:0] tile;
        logic        err;
    } cfg_vec_t;

    typedef struct {
        logic       dreq;
        logic       ren;
        logic       wen;
        logic       gnt;
        logic       gren;
        logic [4:0] graddr;
    } arb_vec_t;

    cfg_vec_t cfg_tab[10];
    arb_vec_t arb_tab[5];

    int n_pass = 0;
    int n_total = 0;
    int n_start, n_ack, n_conv, addr_err, lat_err;
    int first_start_cyc, last_ack_cyc, conv_cyc;
    logic busy_at_conv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [4:0] irrel, input logic [4:0] rel,
                            input logic [2:0] rf, input logic [15:0] tile);
        cfg_irrel_num = irrel;
        cfg_rel_num   = rel;
        cfg_rf_num    = rf;
        cfg_tile_num  = tile;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid     = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic clear_counts();
        n_start = 0; n_ack = 0; n_conv = 0; addr_err = 0; lat_err = 0;
        first_start_cyc = -1; last_ack_cyc = -1; conv_cyc = -1; busy_at_conv = 1'b1;
    endtask

    task automatic wait_start(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (su_start) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    // Acts as su_adder (finish 3 cycles after each su_start) and as the PE array.
    task automatic respond(input int rf, input bit drop_pe, input string nm);
        int  cd;
        int  up_cd;
        int  fin_cyc;
        int  post;
        bit  done;
        cd = 0; up_cd = 0; fin_cyc = -1; post = 0; done = 1'b0;
        for (int i = 1; i <= 600 && post < 6; i++) begin
            tick();
            su_add_finish = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    su_add_finish = 1'b1;
                    fin_cyc = i;
                end
            end
            if (up_cd > 0) begin
                up_cd--;
                if (up_cd == 0) pe_psum_finish = 1'b1;
            end
            if (su_start) begin
                if (psum_rf_addr !== 2'(n_start % rf)) addr_err++;
                if (first_start_cyc < 0) first_start_cyc = i;
                if (fin_cyc >= 0 && (i - fin_cyc) != 2) lat_err++;
                n_start++;
                cd = 3;
            end
            if (pe_psum_ack) begin
                n_ack++;
                last_ack_cyc = i;
                fin_cyc = -1;
                if (drop_pe) begin
                    pe_psum_finish = 1'b0;
                    up_cd = 5;
                end
            end
            if (conv_finish) begin
                n_conv++;
                conv_cyc = i;
                busy_at_conv = busy;
                done = 1'b1;
            end
            if (done) post++;
        end
        su_add_finish = 1'b0;
        chk({nm, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cfg_tab[0] = '{5'd5,  5'd4, 3'd4, 16'd1, 1'b1};
        cfg_tab[1] = '{5'd0,  5'd1, 3'd1, 16'd1, 1'b1};
        cfg_tab[2] = '{5'd17, 5'd1, 3'd1, 16'd1, 1'b1};
        cfg_tab[3] = '{5'd16, 5'd1, 3'd1, 16'd1, 1'b0};
        cfg_tab[4] = '{5'd4,  5'd4, 3'd4, 16'd1, 1'b0};
        cfg_tab[5] = '{5'd1,  5'd0, 3'd1, 16'd1, 1'b1};
        cfg_tab[6] = '{5'd2,  5'd2, 3'd0, 16'd1, 1'b1};
        cfg_tab[7] = '{5'd2,  5'd2, 3'd5, 16'd1, 1'b1};
        cfg_tab[8] = '{5'd2,  5'd2, 3'd4, 16'd0, 1'b1};
        cfg_tab[9] = '{5'd16, 5'd2, 3'd1, 16'd1, 1'b1};

        arb_tab[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h11};
        arb_tab[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'h11};
        arb_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h07};
        arb_tab[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h07};
        arb_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'h11};

        reset = 1'b1; cfg_valid = 1'b0; cfg_irrel_num = '0; cfg_rel_num = '0;
        cfg_rf_num = '0; cfg_tile_num = '0; pe_psum_finish = 1'b0; su_add_finish = 1'b0;
        gbf_if.su_gbf_r_en = 1'b0; gbf_if.su_gbf_w_en = 1'b0;
        gbf_if.su_gbf_r_addr = '0; gbf_if.su_gbf_w_addr = '0;
        gbf_if.drain_req = 1'b0; gbf_if.drain_addr = '0;
        tick();
        tick();
        chk("rst_su_start", 32'(su_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irrel", 32'(su_irrel_num), 32'd0);
        chk("rst_rel", 32'(su_rel_num), 32'd0);
        chk("rst_rf_addr", 32'(psum_rf_addr), 32'd0);
        chk("rst_ack_conv_err", {29'd0, pe_psum_ack, conv_finish, cfg_err}, 32'd0);
        chk("rst_drain_gnt", 32'(gbf_if.drain_gnt), 32'd0);
        reset = 1'b0;
        tick();

        // Basic single tile
        pe_psum_finish = 1'b1;
        send_cfg(5'd4, 5'd3, 3'd4, 16'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_irrel", 32'(su_irrel_num), 32'd4);
        chk("basic_rel", 32'(su_rel_num), 32'd3);
        clear_counts();
        respond(4, 1'b0, "basic");
        chk("basic_starts", 32'(n_start), 32'd4);
        chk("basic_acks", 32'(n_ack), 32'd1);
        chk("basic_convs", 32'(n_conv), 32'd1);
        chk("basic_addr_err", 32'(addr_err), 32'd0);
        chk("basic_fin_to_start_lat", 32'(lat_err), 32'd0);
        chk("basic_pe_to_start_lat", 32'(first_start_cyc), 32'd1);
        chk("basic_ack_to_conv", 32'(conv_cyc - last_ack_cyc), 32'd1);
        chk("basic_busy_at_conv", 32'(busy_at_conv), 32'd0);

        // Multi-tile with PE handshake
        pe_psum_finish = 1'b1;
        send_cfg(5'd2, 5'd2, 3'd2, 16'd3);
        clear_counts();
        respond(2, 1'b1, "multi");
        chk("multi_starts", 32'(n_start), 32'd6);
        chk("multi_acks", 32'(n_ack), 32'd3);
        chk("multi_convs", 32'(n_conv), 32'd1);
        chk("multi_addr_err", 32'(addr_err), 32'd0);
        chk("multi_ack_to_conv", 32'(conv_cyc - last_ack_cyc), 32'd1);

        // Config legality table
        pe_psum_finish = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send_cfg(cfg_tab[k].irrel, cfg_tab[k].rel, cfg_tab[k].rf, cfg_tab[k].tile);
            chk($sformatf("cfg%0d_err", k), 32'(cfg_err), 32'(cfg_tab[k].err));
            chk($sformatf("cfg%0d_busy", k), 32'(busy), 32'(!cfg_tab[k].err));
            tick();
            chk($sformatf("cfg%0d_err_pulse", k), 32'(cfg_err), 32'd0);
            chk($sformatf("cfg%0d_no_start", k), 32'(su_start), 32'd0);
            if (!cfg_tab[k].err) pulse_reset();
        end

        // Arbitration in IDLE
        gbf_if.drain_addr = 5'h11;
        gbf_if.su_gbf_r_addr = 5'h07;
        gbf_if.su_gbf_w_addr = 5'h0C;
        for (int k = 0; k < 5; k++) begin
            gbf_if.drain_req = arb_tab[k].dreq;
            gbf_if.su_gbf_r_en = arb_tab[k].ren;
            gbf_if.su_gbf_w_en = arb_tab[k].wen;
            #1;
            chk($sformatf("idle_arb%0d_gnt", k), 32'(gbf_if.drain_gnt), 32'(arb_tab[k].gnt));
            chk($sformatf("idle_arb%0d_ren", k), 32'(gbf_if.gbf_r_en), 32'(arb_tab[k].gren));
            chk($sformatf("idle_arb%0d_raddr", k), 32'(gbf_if.gbf_r_addr), 32'(arb_tab[k].graddr));
            tick();
        end
        gbf_if.drain_req = 1'b0; gbf_if.su_gbf_r_en = 1'b0; gbf_if.su_gbf_w_en = 1'b0;

        // Arbitration within ADD
        gbf_if.drain_addr = 5'h1A;
        gbf_if.su_gbf_r_addr = 5'h05;
        pe_psum_finish = 1'b1;
        send_cfg(5'd4, 5'd3, 3'd1, 16'd1);
        wait_start("arb_start");
        tick();
        for (int k = 0; k < 6; k++) begin
            gbf_if.drain_req = 1'b1;
            gbf_if.su_gbf_r_en = (k % 2) == 1;
            #1;
            chk($sformatf("add_arb%0d_gnt", k), 32'(gbf_if.drain_gnt), 32'((k % 2) == 0));
            chk($sformatf("add_arb%0d_raddr", k), 32'(gbf_if.gbf_r_addr), ((k % 2) == 1) ? 32'h05 : 32'h1A);
            chk($sformatf("add_arb%0d_ren", k), 32'(gbf_if.gbf_r_en), 32'd1);
            tick();
        end
        gbf_if.su_gbf_r_en = 1'b0;
        gbf_if.su_gbf_w_en = 1'b1;
        #1;
        chk("add_arb_w_gnt", 32'(gbf_if.drain_gnt), 32'd0);
        chk("add_arb_w_en", {30'd0, gbf_if.gbf_w_en, gbf_if.gbf_r_en}, 32'd2);
        chk("add_arb_w_addr", 32'(gbf_if.gbf_w_addr), 32'h0C);
        gbf_if.su_gbf_w_en = 1'b0;
        su_add_finish = 1'b1;
        tick();
        su_add_finish = 1'b0;
        begin
            bit seen_conv;
            seen_conv = 1'b0;
            for (int i = 0; i < 20 && !seen_conv; i++) begin
                tick();
                if (conv_finish) seen_conv = 1'b1;
            end
            chk("arb_job_conv", 32'(seen_conv), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("idle_drain_gnt%0d", k), 32'(gbf_if.drain_gnt), 32'd1);
        end
        gbf_if.drain_req = 1'b0;

        // Reset during the second RF entry
        pe_psum_finish = 1'b1;
        send_cfg(5'd4, 5'd3, 3'd4, 16'd1);
        wait_start("mid_start0");
        tick(); tick(); tick();
        su_add_finish = 1'b1;
        tick();
        su_add_finish = 1'b0;
        wait_start("mid_start1");
        tick();
        chk("mid_addr_before_rst", 32'(psum_rf_addr), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {28'd0, su_start, busy, pe_psum_ack, conv_finish}, 32'd0);
        chk("mid_rst_addr", 32'(psum_rf_addr), 32'd0);
        chk("mid_rst_irrel", 32'(su_irrel_num), 32'd0);
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (pe_psum_ack || conv_finish) stray++;
            end
            reset = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (pe_psum_ack || conv_finish) stray++;
            end
            chk("mid_rst_no_ack_conv", 32'(stray), 32'd0);
        end
        send_cfg(5'd2, 5'd2, 3'd2, 16'd1);
        clear_counts();
        respond(2, 1'b0, "after_rst");
        chk("after_rst_starts", 32'(n_start), 32'd2);
        chk("after_rst_addr_err", 32'(addr_err), 32'd0);
        chk("after_rst_acks_convs", 32'(n_ack * 16 + n_conv), 32'h11);

        // Spurious su_add_finish in WAIT_PE and cfg_valid in ADD
        pe_psum_finish = 1'b0;
        send_cfg(5'd4, 5'd3, 3'd2, 16'd1);
        su_add_finish = 1'b1;
        tick();
        su_add_finish = 1'b0;
        tick(); tick();
        chk("spur_wait_no_start", 32'(su_start), 32'd0);
        chk("spur_wait_busy", 32'(busy), 32'd1);
        chk("spur_wait_addr", 32'(psum_rf_addr), 32'd0);
        pe_psum_finish = 1'b1;
        wait_start("spur_start");
        tick();
        send_cfg(5'd2, 5'd2, 3'd1, 16'd1);
        chk("spur_cfg_irrel", 32'(su_irrel_num), 32'd4);
        chk("spur_cfg_rel", 32'(su_rel_num), 32'd3);
        chk("spur_cfg_state", {30'd0, busy, su_start}, 32'd2);
        tick();
        chk("spur_cfg_no_err", 32'(cfg_err), 32'd0);
        su_add_finish = 1'b1;
        tick();
        su_add_finish = 1'b0;
        clear_counts();
        n_start = 1;
        respond(2, 1'b0, "spur");
        chk("spur_starts", 32'(n_start), 32'd2);
        chk("spur_addr_err", 32'(addr_err), 32'd0);
        chk("spur_acks_convs", 32'(n_ack * 16 + n_conv), 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
